// File: rtl/dsp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsp_pkg : shared DSP helpers (counter sizing, reset polarity)        |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package dsp_pkg;

  localparam logic RST_ACTIVE = 1'b1;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r_bits;
    int r_val;
    r_bits = 0;
    r_val  = value - 1;
    while (r_val > 0) begin
      r_bits = r_bits + 1;
      r_val  = r_val >> 1;
    end
    return r_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dly_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dly_stage : one sample register with async reset, sync clear, enable |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module dly_stage
  import dsp_pkg::*;
#(
  parameter int gp_data_width = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_ena,
  input  logic [gp_data_width-1:0] i_data,
  output logic [gp_data_width-1:0] o_data
);

  logic [gp_data_width-1:0] r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst == RST_ACTIVE) begin
      r_data <= '0;
    end else if (i_clr) begin
      r_data <= '0;
    end else if (i_ena) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/dly_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dly_line : tapped delay line with fill tracking for FIR datapaths    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module dly_line
  import dsp_pkg::*;
#(
  parameter int gp_data_width = 8,
  parameter int gp_depth      = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_ena,
  input  logic                              i_clr,
  input  logic [gp_data_width-1:0]          i_data,
  output logic [gp_depth*gp_data_width-1:0] o_taps,
  output logic [gp_data_width-1:0]          o_data,
  output logic [clog2(gp_depth+1)-1:0]      o_fill,
  output logic                              o_primed
);

  localparam int gp_cnt_width = clog2(gp_depth + 1);
  localparam logic [gp_cnt_width-1:0] c_depth = gp_cnt_width'(gp_depth);

  logic [gp_depth-1:0][gp_data_width-1:0] w_tap;
  logic [gp_cnt_width-1:0]                r_fill;

  generate
    for (genvar k = 0; k < gp_depth; k++) begin : g_stage
      logic [gp_data_width-1:0] w_stage_in;
      if (k == 0) begin : g_head
        assign w_stage_in = i_data;
      end else begin : g_body
        assign w_stage_in = w_tap[k-1];
      end

      dly_stage #(
        .gp_data_width(gp_data_width)
      ) u_stage (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clr),
        .i_ena (i_ena),
        .i_data(w_stage_in),
        .o_data(w_tap[k])
      );
    end
  endgenerate

  // Saturating fill counter shares the stages' priority: reset, clear, enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst == RST_ACTIVE) begin
      r_fill <= '0;
    end else if (i_clr) begin
      r_fill <= '0;
    end else if (i_ena && (r_fill != c_depth)) begin
      r_fill <= r_fill + 1'b1;
    end
  end

  assign o_taps   = w_tap;
  assign o_data   = w_tap[gp_depth-1];
  assign o_fill   = r_fill;
  assign o_primed = (r_fill == c_depth);

endmodule
`default_nettype wire

// File: tb/tb_dly_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dly_line : self-checking bench, queue-based reference model       |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_dly_line;

  localparam int W = 8;
  localparam int D = 4;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_ena, i_clr;
  logic [W-1:0] i_data;
  logic [D*W-1:0] o_taps;
  logic [W-1:0] o_data;
  logic [2:0]   o_fill;
  logic         o_primed;

  logic         ena1, clr1;
  logic [W-1:0] data1;
  logic [W-1:0] taps1, odata1;
  logic [0:0]   fill1;
  logic         primed1;

  int n_vec = 0;
  int n_err = 0;

  // Reference: newest-first history of the last D accepted samples.
  logic [W-1:0] m_hist[$];

  always #5 i_clk = ~i_clk;

  dly_line #(.gp_data_width(W), .gp_depth(D)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ena(i_ena), .i_clr(i_clr), .i_data(i_data),
    .o_taps(o_taps), .o_data(o_data), .o_fill(o_fill), .o_primed(o_primed)
  );

  dly_line #(.gp_data_width(W), .gp_depth(1)) u_dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_ena(ena1), .i_clr(clr1), .i_data(data1),
    .o_taps(taps1), .o_data(odata1), .o_fill(fill1), .o_primed(primed1)
  );

  function automatic logic [D*W-1:0] exp_taps();
    logic [D*W-1:0] r;
    r = '0;
    for (int k = 0; k < D; k++)
      if (k < m_hist.size()) r[k*W +: W] = m_hist[k];
    return r;
  endfunction

  task automatic cycle(input logic ena, input logic clr, input logic [W-1:0] d);
    i_ena = ena; i_clr = clr; i_data = d;
    @(posedge i_clk); #1;
    if (clr) m_hist.delete();
    else if (ena) begin
      m_hist.push_front(d);
      if (m_hist.size() > D) void'(m_hist.pop_back());
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if (o_taps !== '0 || o_fill !== 3'd0 || o_primed !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: taps=%h fill=%0d primed=%b, want 0/0/0", o_taps, o_fill, o_primed);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'hA0 + i));
    #2 i_rst = 1'b1;
    #1;
    m_hist.delete();
    n_vec++;
    if (o_taps !== '0 || o_data !== '0 || o_fill !== 3'd0 || o_primed !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: taps=%h data=%h fill=%0d primed=%b, want zeros", o_taps, o_data, o_fill, o_primed);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [7:0] s[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, s[i]);
      n_vec++;
      if (o_primed !== (i == 3) || o_fill !== 3'(i + 1)) begin
        n_err++;
        $display("FAIL fill_edge%0d: fill=%0d primed=%b, want %0d/%b", i + 1, o_fill, o_primed, i + 1, i == 3);
      end
    end
    n_vec++;
    if (o_taps !== 32'h11223344 || o_data !== 8'h11) begin
      n_err++;
      $display("FAIL fill_taps: taps=%h data=%h, want 11223344/11", o_taps, o_data);
    end
  endtask

  task automatic test_gated();
    logic [7:0] s[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    cycle(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cycle(i % 2 == 0, 1'b0, (i % 2 == 0) ? s[i/2] : 8'hEE);
      n_vec++;
      if (o_fill !== 3'(i/2 + 1)) begin
        n_err++;
        $display("FAIL gated_fill%0d: fill=%0d, want %0d", i + 1, o_fill, i/2 + 1);
      end
    end
    n_vec++;
    if (o_taps !== 32'h11223344) begin
      n_err++;
      $display("FAIL gated_taps: taps=%h, want 11223344", o_taps);
    end
  endtask

  task automatic test_saturation();
    cycle(1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      n_vec++;
      if (o_fill !== 3'((i < D) ? i : D)) begin
        n_err++;
        $display("FAIL sat_fill%0d: fill=%0d, want %0d", i, o_fill, (i < D) ? i : D);
      end
    end
    n_vec++;
    if (o_taps !== 32'h0708090A || o_primed !== 1'b1) begin
      n_err++;
      $display("FAIL sat_taps: taps=%h primed=%b, want 0708090A/1", o_taps, o_primed);
    end
  endtask

  task automatic test_clear();
    cycle(1'b1, 1'b1, 8'h55);
    n_vec++;
    if (o_taps !== '0 || o_fill !== 3'd0 || o_primed !== 1'b0) begin
      n_err++;
      $display("FAIL clear_prio: taps=%h fill=%0d primed=%b, want 0/0/0", o_taps, o_fill, o_primed);
    end
    cycle(1'b0, 1'b0, 8'h66);
    n_vec++;
    if (o_taps !== '0) begin
      n_err++;
      $display("FAIL clear_hold: taps=%h, want 0", o_taps);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, 8'($urandom));
      n_vec++;
      if (o_taps !== exp_taps() || o_data !== exp_taps()[D*W-1 -: W] ||
          o_fill !== 3'(m_hist.size()) || o_primed !== (m_hist.size() == D)) begin
        n_err++;
        $display("FAIL random%0d: taps=%h fill=%0d primed=%b, want %h/%0d/%b", i, o_taps, o_fill,
                 o_primed, exp_taps(), m_hist.size(), m_hist.size() == D);
      end
    end
  endtask

  task automatic test_depth1();
    n_vec++;
    if (odata1 !== 8'h00 || fill1 !== 1'b0 || primed1 !== 1'b0) begin
      n_err++;
      $display("FAIL d1_reset: data=%h fill=%0d primed=%b, want 00/0/0", odata1, fill1, primed1);
    end
    ena1 = 1'b1; data1 = 8'hA5;
    @(posedge i_clk); #1;
    ena1 = 1'b0; data1 = 8'h3C;
    n_vec++;
    if (odata1 !== 8'hA5 || taps1 !== 8'hA5 || fill1 !== 1'b1 || primed1 !== 1'b1) begin
      n_err++;
      $display("FAIL d1_enable: data=%h taps=%h fill=%0d primed=%b, want A5/A5/1/1", odata1, taps1, fill1, primed1);
    end
    @(posedge i_clk); #1;
    n_vec++;
    if (odata1 !== 8'hA5) begin
      n_err++;
      $display("FAIL d1_hold: data=%h, want A5", odata1);
    end
    clr1 = 1'b1; ena1 = 1'b1;
    @(posedge i_clk); #1;
    clr1 = 1'b0; ena1 = 1'b0;
    n_vec++;
    if (odata1 !== 8'h00 || fill1 !== 1'b0 || primed1 !== 1'b0) begin
      n_err++;
      $display("FAIL d1_clear: data=%h fill=%0d primed=%b, want 00/0/0", odata1, fill1, primed1);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_ena = 1'b0; i_clr = 1'b0; i_data = '0;
    ena1 = 1'b0; clr1 = 1'b0; data1 = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    test_depth1();
    test_reset();
    test_fill();
    test_gated();
    test_saturation();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
